// File: rtl/lpm_shiftreg_burst.sv
// Parametrised LPM shift register with run-time direction, multi-bit step,
// an enable-qualified output delay pipeline and a self-timed burst mode.
// Start loads Data, then the register shifts Len steps on its own.
// Busy is high for the length of the burst and Done pulses once at the end.
module lpm_shiftreg_burst #(
    parameter int               WIDTH  = 16,
    parameter int               STEP   = 1,
    parameter int               DELAY  = 0,
    parameter int               CNTW   = 5,
    parameter logic [WIDTH-1:0] AVALUE = '1,
    parameter logic [WIDTH-1:0] SVALUE = '1
) (
    input  logic             Clock,
    input  logic             Aclr,
    input  logic             Aset,
    input  logic             Enable,
    input  logic             Sclr,
    input  logic             Sset,
    input  logic             Load,
    input  logic             Start,
    input  logic             Dir,
    input  logic [CNTW-1:0]  Len,
    input  logic [WIDTH-1:0] Data,
    input  logic [STEP-1:0]  ShiftIn,
    output logic [WIDTH-1:0] Q,
    output logic [STEP-1:0]  ShiftOut,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] r, r_nxt, r_rsh, r_lsh;
    logic [CNTW-1:0]  cnt, cnt_nxt;
    logic             dl, dl_nxt;
    logic             done_q, done_nxt;
    logic             dir_eff;

    // Both shift results are always available; the FSM picks one.
    assign r_rsh = {ShiftIn, r[WIDTH-1:STEP]};
    assign r_lsh = {r[WIDTH-STEP-1:0], ShiftIn};

    // A burst uses its latched direction. In IDLE the live Dir decides which
    // bits the next shift will expel.
    assign dir_eff = (state == SHIFT) ? dl : Dir;

    assign Busy = (state == SHIFT);
    assign Done = done_q;

    // FSM state register; both async controls abort to IDLE
    always_ff @(posedge Clock or posedge Aclr or posedge Aset) begin
        if (Aclr)
            state <= IDLE;
        else if (Aset)
            state <= IDLE;
        else if (Enable)
            state <= state_nxt;
    end

    // Next-state and next-datapath values; every value holds unless Enable is high
    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        cnt_nxt   = cnt;
        dl_nxt    = dl;
        done_nxt  = 1'b0;
        if (Enable) begin
            if (Sclr) begin
                r_nxt     = '0;
                state_nxt = IDLE;
            end else if (Sset) begin
                r_nxt     = SVALUE;
                state_nxt = IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (Start) begin
                            r_nxt   = Data;
                            cnt_nxt = Len;
                            dl_nxt  = Dir;
                            // A zero-length burst completes without leaving IDLE
                            if (Len != '0)
                                state_nxt = SHIFT;
                            else
                                done_nxt = 1'b1;
                        end else if (Load) begin
                            r_nxt = Data;
                        end else begin
                            r_nxt = Dir ? r_lsh : r_rsh;
                        end
                    end
                    SHIFT: begin
                        r_nxt   = dl ? r_lsh : r_rsh;
                        cnt_nxt = cnt - CNTW'(1);
                        if (cnt == CNTW'(1)) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Core register, burst counter, latched direction and the Done pulse.
    // Done is reloaded on every edge, so it never lasts longer than one cycle.
    always_ff @(posedge Clock or posedge Aclr or posedge Aset) begin
        if (Aclr) begin
            r      <= '0;
            cnt    <= '0;
            dl     <= 1'b0;
            done_q <= 1'b0;
        end else if (Aset) begin
            r      <= AVALUE;
            cnt    <= '0;
            dl     <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_nxt;
            if (Enable) begin
                r   <= r_nxt;
                cnt <= cnt_nxt;
                dl  <= dl_nxt;
            end
        end
    end

    generate
        if (DELAY == 0) begin : g_nodly
            assign Q        = r;
            assign ShiftOut = dir_eff ? r[WIDTH-1 -: STEP] : r[STEP-1:0];
        end else begin : g_dly
            // The direction travels alongside the data, so a delayed ShiftOut
            // matches the delayed Q it was taken from.
            logic [DELAY:1][WIDTH-1:0] q_pipe;
            logic [DELAY:1]            dir_pipe;

            // Output pipeline; it advances only on enabled edges
            always_ff @(posedge Clock or posedge Aclr or posedge Aset) begin
                if (Aclr) begin
                    q_pipe   <= '0;
                    dir_pipe <= '0;
                end else if (Aset) begin
                    q_pipe   <= {DELAY{AVALUE}};
                    dir_pipe <= '0;
                end else if (Enable) begin
                    if (Sclr) begin
                        q_pipe   <= '0;
                        dir_pipe <= '0;
                    end else if (Sset) begin
                        q_pipe   <= {DELAY{SVALUE}};
                        dir_pipe <= '0;
                    end else begin
                        q_pipe[1]   <= r;
                        dir_pipe[1] <= dir_eff;
                        for (int i = 2; i <= DELAY; i++) begin
                            q_pipe[i]   <= q_pipe[i-1];
                            dir_pipe[i] <= dir_pipe[i-1];
                        end
                    end
                end
            end

            assign Q        = q_pipe[DELAY];
            assign ShiftOut = dir_pipe[DELAY] ? q_pipe[DELAY][WIDTH-1 -: STEP]
                                              : q_pipe[DELAY][STEP-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_lpm_shiftreg_burst.sv
// Bench for lpm_shiftreg_burst. It runs three instances on shared controls:
// STEP=1/DELAY=0, STEP=4/DELAY=0 and STEP=1/DELAY=2.
module tb_lpm_shiftreg_burst;

    logic        Clock = 1'b0;
    logic        Aclr, Aset, Enable, Sclr, Sset, Load, Start, Dir;
    logic [4:0]  Len;
    logic [15:0] Data;
    logic [0:0]  si1;
    logic [3:0]  si4;

    logic [15:0] q1, q4, qd;
    logic [0:0]  so1, sod;
    logic [3:0]  so4;
    logic        busy1, done1, busy4, done4, busyd, doned;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q [$];
    logic [15:0] e;

    always #5 Clock = ~Clock;

    lpm_shiftreg_burst #(.WIDTH(16), .STEP(1), .DELAY(0)) u1 (
        .Clock(Clock), .Aclr(Aclr), .Aset(Aset), .Enable(Enable), .Sclr(Sclr), .Sset(Sset),
        .Load(Load), .Start(Start), .Dir(Dir), .Len(Len), .Data(Data), .ShiftIn(si1),
        .Q(q1), .ShiftOut(so1), .Busy(busy1), .Done(done1));

    lpm_shiftreg_burst #(.WIDTH(16), .STEP(4), .DELAY(0)) u4 (
        .Clock(Clock), .Aclr(Aclr), .Aset(Aset), .Enable(Enable), .Sclr(Sclr), .Sset(Sset),
        .Load(Load), .Start(Start), .Dir(Dir), .Len(Len), .Data(Data), .ShiftIn(si4),
        .Q(q4), .ShiftOut(so4), .Busy(busy4), .Done(done4));

    lpm_shiftreg_burst #(.WIDTH(16), .STEP(1), .DELAY(2)) ud (
        .Clock(Clock), .Aclr(Aclr), .Aset(Aset), .Enable(Enable), .Sclr(Sclr), .Sset(Sset),
        .Load(Load), .Start(Start), .Dir(Dir), .Len(Len), .Data(Data), .ShiftIn(si1),
        .Q(qd), .ShiftOut(sod), .Busy(busyd), .Done(doned));

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Aclr = 1'b1;
        #3;
        n_cmp++; if (q1 !== 16'h0)    begin n_err++; $display("FAIL reset_q: got %h want 0000", q1); end
        n_cmp++; if (so1 !== 1'b0)    begin n_err++; $display("FAIL reset_so: got %h want 0", so1); end
        n_cmp++; if (busy1 !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", busy1); end
        n_cmp++; if (done1 !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b want 0", done1); end
        n_cmp++; if (qd !== 16'h0)    begin n_err++; $display("FAIL reset_qd: got %h want 0000", qd); end
        Aclr = 1'b0;
        tick();
    endtask

    task automatic test_load_shift();
        logic [15:0] v;
        Enable = 1'b1; Dir = 1'b0; Data = 16'hA5C3; Load = 1'b1;
        exp_q.push_back(16'hA5C3);
        tick();
        Load = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (q1 !== e)     begin n_err++; $display("FAIL load_q: got %h want %h", q1, e); end
        n_cmp++; if (so1 !== 1'b1) begin n_err++; $display("FAIL load_so: got %h want 1", so1); end
        si1 = 1'b1;
        exp_q.push_back(16'hD2E1);
        tick();
        e = exp_q.pop_front();
        n_cmp++; if (q1 !== e) begin n_err++; $display("FAIL rshift_q: got %h want %h", q1, e); end
        v = 16'hD2E1;
        for (int i = 0; i < 8; i++) begin
            Dir  = 1'($urandom_range(0, 1));
            si1  = 1'($urandom_range(0, 1));
            Load = ($urandom_range(0, 3) == 0);
            Data = 16'($urandom);
            if (Load)     v = Data;
            else if (Dir) v = (v << 1) | {15'h0, si1};
            else          v = (v >> 1) | {si1, 15'h0};
            exp_q.push_back(v);
            tick();
            e = exp_q.pop_front();
            n_cmp++; if (q1 !== e) begin n_err++; $display("FAIL rand_q[%0d]: got %h want %h", i, q1, e); end
            n_cmp++; if (so1 !== (Dir ? e[15] : e[0]))
                begin n_err++; $display("FAIL rand_so[%0d]: got %h want %h", i, so1, Dir ? e[15] : e[0]); end
        end
        Load = 1'b0; Dir = 1'b0; si1 = 1'b0;
    endtask

    task automatic test_step4();
        Enable = 1'b1; Dir = 1'b1; Data = 16'h1234; Load = 1'b1;
        exp_q.push_back(16'h1234);
        tick();
        Load = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (q4 !== e)     begin n_err++; $display("FAIL s4_load_q: got %h want %h", q4, e); end
        n_cmp++; if (so4 !== 4'h1) begin n_err++; $display("FAIL s4_left_so: got %h want 1", so4); end
        n_cmp++; if (busy4 !== 1'b0 || done4 !== 1'b0)
            begin n_err++; $display("FAIL s4_status: got %b%b want 00", busy4, done4); end
        si4 = 4'hF;
        exp_q.push_back(16'h234F);
        tick();
        e = exp_q.pop_front();
        n_cmp++; if (q4 !== e) begin n_err++; $display("FAIL s4_lshift_q: got %h want %h", q4, e); end
        Dir = 1'b0; si4 = 4'h0;
        exp_q.push_back(16'h0234);
        tick();
        e = exp_q.pop_front();
        n_cmp++; if (q4 !== e)     begin n_err++; $display("FAIL s4_rshift_q: got %h want %h", q4, e); end
        n_cmp++; if (so4 !== 4'h4) begin n_err++; $display("FAIL s4_right_so: got %h want 4", so4); end
    endtask

    task automatic test_burst(input bit stall);
        int bc, dc;
        bc = 0; dc = 0;
        Enable = 1'b1; Data = 16'h8001; Len = 5'd3; Dir = 1'b0; si1 = 1'b0; Start = 1'b1;
        exp_q.push_back(16'h1000);
        tick();
        Start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy1) bc++;
            if (done1) begin
                dc++;
                e = exp_q.pop_front();
                n_cmp++; if (q1 !== e) begin n_err++; $display("FAIL burst_q(stall=%0d): got %h want %h", stall, q1, e); end
            end
            Enable = !(stall && (i == 1 || i == 2));
            tick();
        end
        Enable = 1'b1;
        exp_q.delete();
        n_cmp++; if (bc != (stall ? 5 : 3))
            begin n_err++; $display("FAIL burst_busy_cycles(stall=%0d): got %0d want %0d", stall, bc, stall ? 5 : 3); end
        n_cmp++; if (dc != 1)
            begin n_err++; $display("FAIL burst_done_pulses(stall=%0d): got %0d want 1", stall, dc); end
    endtask

    task automatic test_abort(input bit use_aclr);
        int dc;
        dc = 0;
        Enable = 1'b1; Data = 16'h8001; Len = 5'd5; Dir = 1'b0; si1 = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        exp_q.push_back(16'h0000);
        if (!use_aclr) begin
            Sclr = 1'b1;
            tick();
            Sclr = 1'b0;
        end else begin
            #2 Aclr = 1'b1;
            #1;
        end
        e = exp_q.pop_front();
        n_cmp++; if (q1 !== e)     begin n_err++; $display("FAIL abort_q(aclr=%0d): got %h want %h", use_aclr, q1, e); end
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL abort_busy(aclr=%0d): got %b want 0", use_aclr, busy1); end
        Aclr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done1) dc++;
            tick();
        end
        n_cmp++; if (dc != 0)      begin n_err++; $display("FAIL abort_done(aclr=%0d): got %0d pulses want 0", use_aclr, dc); end
        n_cmp++; if (q1 !== 16'h0) begin n_err++; $display("FAIL abort_q_after(aclr=%0d): got %h want 0000", use_aclr, q1); end
    endtask

    task automatic test_len0();
        int bc, dc;
        bc = 0; dc = 0;
        Enable = 1'b1; Data = 16'h00F0; Len = 5'd0; Dir = 1'b0; si1 = 1'b0; Start = 1'b1;
        exp_q.push_back(16'h00F0);
        tick();
        Start = 1'b0; Enable = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (q1 !== e)       begin n_err++; $display("FAIL len0_q: got %h want %h", q1, e); end
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL len0_busy: got %b want 0", busy1); end
        n_cmp++; if (done1 !== 1'b1) begin n_err++; $display("FAIL len0_done: got %b want 1", done1); end
        tick();
        n_cmp++; if (done1 !== 1'b0) begin n_err++; $display("FAIL done_one_cycle_en_low: got %b want 0", done1); end
        // Start held through the burst with different Data/Len must not restart it
        Enable = 1'b1; Data = 16'h8001; Len = 5'd3; Start = 1'b1;
        exp_q.push_back(16'h1000);
        tick();
        Data = 16'hFFFF; Len = 5'd2;
        for (int i = 0; i < 10; i++) begin
            if (busy1) bc++;
            if (done1) begin
                dc++;
                Start = 1'b0;
                e = exp_q.pop_front();
                n_cmp++; if (q1 !== e) begin n_err++; $display("FAIL busy_start_q: got %h want %h", q1, e); end
            end
            tick();
        end
        Start = 1'b0;
        exp_q.delete();
        n_cmp++; if (bc != 3) begin n_err++; $display("FAIL busy_start_cycles: got %0d want 3", bc); end
        n_cmp++; if (dc != 1) begin n_err++; $display("FAIL busy_start_done: got %0d want 1", dc); end
    endtask

    task automatic test_delay();
        logic [15:0] exp_tab [6];
        exp_tab = '{16'hFFFF, 16'hFFFF, 16'h00FF, 16'h007F, 16'h007F, 16'h007F};
        Dir = 1'b0; si1 = 1'b0;
        Aset = 1'b1;
        #1;
        n_cmp++; if (qd !== 16'hFFFF) begin n_err++; $display("FAIL dly_aset_q: got %h want ffff", qd); end
        n_cmp++; if (busyd !== 1'b0 || doned !== 1'b0)
            begin n_err++; $display("FAIL dly_aset_status: got %b%b want 00", busyd, doned); end
        Aset = 1'b0;
        Data = 16'h00FF;
        for (int i = 0; i < 6; i++) begin
            Load   = (i == 0);
            Enable = (i < 4);
            exp_q.push_back(exp_tab[i]);
            tick();
            e = exp_q.pop_front();
            n_cmp++; if (qd !== e)     begin n_err++; $display("FAIL dly_q[%0d]: got %h want %h", i, qd, e); end
            n_cmp++; if (sod !== e[0]) begin n_err++; $display("FAIL dly_so[%0d]: got %h want %h", i, sod, e[0]); end
        end
        Load = 1'b0; Enable = 1'b1;
    endtask

    initial begin
        Aclr = 1'b0; Aset = 1'b0; Enable = 1'b1; Sclr = 1'b0; Sset = 1'b0;
        Load = 1'b0; Start = 1'b0; Dir = 1'b0; Len = '0; Data = '0; si1 = '0; si4 = '0;
        test_reset();
        test_load_shift();
        test_step4();
        test_burst(1'b0);
        test_burst(1'b1);
        test_abort(1'b0);
        test_abort(1'b1);
        test_len0();
        test_delay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lpm_shiftreg_burst.md
# lpm_shiftreg_burst

Parametrised successor to the fixed 16-bit LPM shift register. It supports any width, multi-bit shift step, run-time shift direction, and an output delay pipeline that is correctly aligned. It also adds a burst mode: `Start` loads a word and shifts it `Len` steps on its own, with `Busy` and `Done` status. It sits between the parallel datapath and serial links, in the same role as the existing LPM shift registers.

## Interface
- `WIDTH`, 16: register width; must be at least 2.
- `STEP`, 1: bits shifted per shift event; 1 ≤ STEP < WIDTH.
- `DELAY`, 0: number of enabled-edge pipeline stages on `Q` and `ShiftOut`; 0 means no pipeline.
- `CNTW`, 5: width of `Len` and of the burst counter.
- `AVALUE`, all ones: value loaded by `Aset`.
- `SVALUE`, all ones: value loaded by `Sset`.
- `Clock`  in  1  system clock, rising edge.
- `Aclr`  in  1  asynchronous clear; reset Aclr, asynchronous, active-high; clock Clock.
- `Aset`  in  1  asynchronous set to `AVALUE`, active-high.
- `Enable`  in  1  qualifies every synchronous action and every pipeline advance.
- `Sclr`, `Sset`  in  1  synchronous clear / set.
- `Load`  in  1  parallel load (IDLE only).
- `Start`  in  1  burst start (IDLE only).
- `Dir`  in  1  shift direction: 0 = right, 1 = left.
- `Len`  in  CNTW  burst length, in shift events.
- `Data`  in  WIDTH  parallel load data.
- `ShiftIn`  in  STEP  serial input.
- `Q`  out  WIDTH  register contents after DELAY pipeline stages.
- `ShiftOut`  out  STEP  bits that the next shift will expel, after DELAY pipeline stages.
- `Busy`  out  1  high while in state SHIFT.
- `Done`  out  1  one-cycle pulse when a burst completes.

## Operation
- **State.** Core register R[WIDTH-1:0]; counter C[CNTW-1:0]; latched direction DL; FSM with states IDLE and SHIFT.
- **Right shift.** R ← {ShiftIn, R[WIDTH-1:STEP]}. `ShiftIn[STEP-1]` lands in R[WIDTH-1]. Core `ShiftOut` = R[STEP-1:0].
- **Left shift.** R ← {R[WIDTH-STEP-1:0], ShiftIn}. Core `ShiftOut` = R[WIDTH-1:WIDTH-STEP].
- **Priority.** Aclr > Aset > (Enable-gated) Sclr > Sset > state action.
- **Aclr.** R, all pipeline stages, C and `Done` go to 0; FSM goes to IDLE.
- **Aset.** R and all pipeline stages go to AVALUE; C and `Done` go to 0; FSM goes to IDLE.
- **Sclr / Sset (Enable high).** R and all pipeline stages go to 0 (Sclr) or SVALUE (Sset). The FSM is forced to IDLE, aborting any burst with no `Done`.
- **IDLE, Enable high, in priority order:**
  - `Start`: R ← Data, C ← Len, DL ← Dir. Go to SHIFT if Len ≠ 0. If Len = 0, stay in IDLE and pulse `Done` next cycle.
  - `Load`: R ← Data.
  - Otherwise: shift one STEP in direction `Dir` (live value).
- **SHIFT, Enable high.** Shift one STEP in direction DL; C ← C − 1. When C goes from 1 to 0: go to IDLE and register `Done` = 1.
  - `Load`, `Start` and `Dir` are ignored while in SHIFT.
- **Enable low.** R, C, FSM state and pipeline all hold. `Done` still clears after its one cycle.
- **Delay pipeline.** With DELAY > 0, `Q`/`ShiftOut` are the core values delayed by DELAY *enabled* edges. `Busy` and `Done` are not delayed, so final burst data appears on `Q` DELAY enabled edges after `Done`.

## Timing
- **Reset values.** Q = 0, ShiftOut = 0, Busy = 0, Done = 0.
- **Loads and shifts.** Visible on `Q` right after edge k when DELAY = 0; after edge k+DELAY otherwise (all intermediate edges enabled).
- **Burst.** `Start` at edge k. `Busy` is high from after edge k until after edge k+Len. `Done` is high for the one cycle after edge k+Len. A new `Start` is accepted at edge k+Len+1.
- **`Done` with Enable low.** `Done` is an unconditional one-cycle pulse and is not stretched by Enable low.
- **Asynchronous controls mid-burst.** `Aclr`/`Aset` mid-burst act immediately and do not wait for a clock edge. Deassertion is synchronised by the integrator.
- **`Start` and `Load` together in IDLE.** `Start` wins.
- **`Sclr` and `Start` together.** `Sclr` wins; no burst starts.

## Test plan
1. WIDTH=16, STEP=1, DELAY=0: Aclr pulse → Q=0x0000, Busy=0, Done=0. Load 0xA5C3 → Q=0xA5C3, ShiftOut=1. One right shift with ShiftIn=1 → Q=0xD2E1.
2. STEP=4: Load 0x1234, ShiftOut=0x1 with Dir=1. Left shift with ShiftIn=0xF → Q=0x234F. Then Dir=0, ShiftIn=0x0 → Q=0x0234.
3. Burst: Start with Data=0x8001, Len=3, Dir=0, ShiftIn=0 → Busy high for 3 cycles, then Done pulses once and Q=0x1000. Repeat with Enable low for 2 cycles mid-burst → Busy stretches by 2 cycles; same final Q.
4. Abort: Sclr at the second shift of a Len=5 burst → Q=0, Busy=0, Done never pulses. Repeat using Aclr asserted asynchronously between edges → same result.
5. Len=0 Start with Data=0x00F0 → Busy stays 0, Q=0x00F0, Done pulses the next cycle. Start asserted during Busy is ignored.
6. DELAY=2: Aset → Q=0xFFFF immediately. Load 0x00FF at edge k, then hold → Q=0x00FF after edge k+2. Dropping Enable freezes the pipeline.
